// File: rtl/uart_pkg.sv
// Shared definitions for the queued 8N1 UART transmitter.
package uart_pkg;

  // Transmit FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // One start bit, eight data bits and one stop bit per frame
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

  // Smallest usable bit period in clock cycles
  localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with a registered occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  // Flags come straight from the registered count
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == LW'(DEPTH));
  assign o_level   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Overflowing writes and underflowing reads are ignored
  assign w_wr = i_wr_en && !o_full;
  assign w_rd = i_rd_en && !o_empty;

  // Storage array; no reset needed, contents are qualified by the count
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointer and count update; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// 8N1 UART transmitter fed by a byte FIFO; frames go out back-to-back, LSB first.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic [DIV_WIDTH-1:0] r_div_q;
  logic [DIV_WIDTH-1:0] w_div_q_nxt;
  logic [2:0]           r_bit_idx;
  logic [2:0]           w_bit_idx_nxt;
  logic [7:0]           r_shreg;
  logic [7:0]           w_shreg_nxt;
  logic                 r_ser_tx;
  logic                 w_ser_tx_nxt;
  logic                 w_pop;
  logic                 w_push;
  logic [7:0]           w_fifo_data;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [LW-1:0]        w_level;
  logic [DIV_WIDTH-1:0] w_div_clamp;
  logic                 w_bit_done;

  // Byte queue between the producer and the shifter
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_push),
    .i_wr_data (in_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full),
    .o_level   (w_level)
  );

  // Ready is based on the registered count only, so a pop never frees a slot in the same cycle
  assign in_ready   = !w_fifo_full;
  assign w_push     = in_valid && in_ready;
  assign fifo_level = w_level;
  assign busy       = (r_state != ST_IDLE) || (w_level != '0);
  assign ser_tx     = r_ser_tx;

  // Bit period used for the next frame; 0 and 1 would make bits too short to time
  assign w_div_clamp = (cfg_div < DIV_WIDTH'(DIV_MIN)) ? DIV_WIDTH'(DIV_MIN) : cfg_div;
  assign w_bit_done  = (r_cnt == '0);

  // State and datapath registers; reset drops the line high immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_div_q   <= DIV_WIDTH'(DIV_MIN);
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_ser_tx  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div_q   <= w_div_q_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shreg   <= w_shreg_nxt;
      r_ser_tx  <= w_ser_tx_nxt;
    end
  end

  // Next-state, bit timer and line level; the line register lags the state by one cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_div_q_nxt   = r_div_q;
    w_bit_idx_nxt = r_bit_idx;
    w_shreg_nxt   = r_shreg;
    w_ser_tx_nxt  = 1'b1;
    w_pop         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_ser_tx_nxt = 1'b1;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shreg_nxt = w_fifo_data;
          w_div_q_nxt = w_div_clamp;
          w_cnt_nxt   = w_div_clamp - DIV_WIDTH'(1);
          w_state_nxt = ST_START;
        end
      end

      ST_START: begin
        w_ser_tx_nxt = 1'b0;
        if (w_bit_done) begin
          w_cnt_nxt     = r_div_q - DIV_WIDTH'(1);
          w_bit_idx_nxt = '0;
          w_state_nxt   = ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
        end
      end

      ST_DATA: begin
        w_ser_tx_nxt = r_shreg[r_bit_idx];
        if (w_bit_done) begin
          w_cnt_nxt = r_div_q - DIV_WIDTH'(1);
          if (r_bit_idx == 3'(DATA_BITS - 1)) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
        end
      end

      ST_STOP: begin
        w_ser_tx_nxt = 1'b1;
        if (w_bit_done) begin
          if (!w_fifo_empty) begin
            // Chain straight into the next frame with no idle gap
            w_pop       = 1'b1;
            w_shreg_nxt = w_fifo_data;
            w_div_q_nxt = w_div_clamp;
            w_cnt_nxt   = w_div_clamp - DIV_WIDTH'(1);
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue against a cycle-timeline transaction model.
module tb_uart_tx_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg_div;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ser_tx;
  logic        busy;
  logic [4:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  // Line value seen after each clock edge of the current scenario
  logic rec_q[$];

  // Transaction model: pending bytes, the frame on the wire and when the next pop may happen
  logic [7:0] m_q[$];
  longint     m_t = 0;
  longint     m_next_free = 0;
  bit         m_has = 0;
  longint     m_p = 0;
  int         m_div = 2;
  logic [7:0] m_byte = '0;
  logic       m_line = 1'b1;
  logic       m_busy = 1'b0;
  int         m_level = 0;
  bit         m_ready = 1'b1;

  always #5 clk = ~clk;

  uart_tx_queue #(
    .FIFO_DEPTH (16),
    .DIV_WIDTH  (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_div    (cfg_div),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  // Bit k of an 8N1 frame: start, eight data bits LSB first, stop
  function automatic logic frame_bit(logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Read a byte out of the recorded line, sampling the middle of each data bit
  function automatic logic [7:0] decode(int s, int div);
    logic [7:0] b;
    int idx;
    for (int k = 0; k < 8; k++) begin
      idx = s + (k + 1) * div + div / 2;
      b[k] = (idx < rec_q.size()) ? rec_q[idx] : 1'bx;
    end
    return b;
  endfunction

  // Advance the model by one rising edge using the inputs currently driven
  task automatic model_step();
    int     pre;
    longint off;
    m_t++;
    if (reset) begin
      m_q.delete();
      m_has       = 1'b0;
      m_next_free = m_t;
      m_line      = 1'b1;
      m_busy      = 1'b0;
      m_level     = 0;
      m_ready     = 1'b1;
      return;
    end
    off = m_t - 1 - m_p;
    if (m_has && off >= 0 && off < 10 * m_div) m_line = frame_bit(m_byte, int'(off / m_div));
    else m_line = 1'b1;
    pre = m_q.size();
    if (pre > 0 && m_t >= m_next_free) begin
      m_byte      = m_q.pop_front();
      m_p         = m_t;
      m_div       = (cfg_div < 2) ? 2 : int'(cfg_div);
      m_next_free = m_t + 10 * m_div;
      m_has       = 1'b1;
    end
    if (in_valid && pre != 16) m_q.push_back(in_data);
    m_level = m_q.size();
    m_busy  = (m_t < m_next_free) || (m_level != 0);
    m_ready = (m_level != 16);
  endtask

  // One clock: model update, edge, then sample on the falling edge
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    rec_q.push_back(ser_tx);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; cfg_div = 32'd6;
    repeat (4) begin
      tick();
      n_checks += 4;
      if (ser_tx !== 1'b1)      begin n_fail++; $display("FAIL reset_ser_tx: got %b want 1", ser_tx); end
      if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (fifo_level !== 5'd0)  begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int first;
    int err;
    cfg_div = 32'd6;
    rec_q.delete();
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    repeat (63) begin
      tick();
      n_checks++;
      if (ser_tx !== m_line) begin n_fail++; $display("FAIL single_line t=%0d: got %b want %b", m_t, ser_tx, m_line); end
    end
    first = -1;
    foreach (rec_q[i]) if (rec_q[i] === 1'b0 && first < 0) first = i;
    n_checks++;
    if (first != 2) begin n_fail++; $display("FAIL single_start_latency: got %0d want 2", first); end
    err = 0;
    for (int i = 0; i < 60; i++) if (rec_q[2+i] !== 1'((i / 6) % 2)) err++;
    n_checks++;
    if (err != 0) begin n_fail++; $display("FAIL single_pattern: %0d wrong cycles want 0", err); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_hello();
    string      msg;
    string      got;
    logic [7:0] b;
    msg = "Hello";
    got = "";
    cfg_div = 32'd6;
    rec_q.delete();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = msg[i];
      tick();
      n_checks++;
      if (ser_tx !== m_line) begin n_fail++; $display("FAIL hello_line t=%0d: got %b want %b", m_t, ser_tx, m_line); end
    end
    in_valid = 1'b0;
    repeat (300) begin
      tick();
      n_checks++;
      if (ser_tx !== m_line) begin n_fail++; $display("FAIL hello_line t=%0d: got %b want %b", m_t, ser_tx, m_line); end
    end
    for (int f = 0; f < 5; f++) begin
      n_checks += 2;
      if (rec_q[2 + 60*f] !== 1'b0) begin n_fail++; $display("FAIL hello_gap frame %0d: start bit got %b want 0", f, rec_q[2 + 60*f]); end
      b = decode(2 + 60*f, 6);
      if (b !== msg[f]) begin n_fail++; $display("FAIL hello_byte %0d: got %02h want %02h", f, b, msg[f]); end
      got = {got, string'(b)};
    end
    $display("serial monitor: \"%s\"", got);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hello_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int  base;
    int  sent;
    int  guard;
    bit  acc;
    bit  saw_full;
    logic [7:0] b;
    cfg_div = 32'd4;
    rec_q.delete();
    base = int'($urandom_range(0, 255));
    sent = 0; guard = 0; saw_full = 1'b0;
    while (sent < 20 && guard < 400) begin
      in_valid = 1'b1; in_data = 8'(base + sent);
      acc = m_ready;
      tick();
      guard++;
      if (acc) sent++;
      n_checks += 3;
      if (ser_tx !== m_line)    begin n_fail++; $display("FAIL bp_line t=%0d: got %b want %b", m_t, ser_tx, m_line); end
      if (in_ready !== m_ready) begin n_fail++; $display("FAIL bp_in_ready t=%0d: got %b want %b", m_t, in_ready, m_ready); end
      if (fifo_level !== 5'(m_level)) begin n_fail++; $display("FAIL bp_level t=%0d: got %0d want %0d", m_t, fifo_level, m_level); end
      if (in_ready === 1'b0) begin
        n_checks++;
        if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL bp_ready_drop: level got %0d want 16", fifo_level); end
        saw_full = 1'b1;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (sent != 20) begin n_fail++; $display("FAIL bp_accept_timeout: accepted %0d want 20", sent); end
    n_checks++;
    if (!saw_full) begin n_fail++; $display("FAIL bp_saw_full: got 0 want 1"); end
    guard = 0;
    while ((m_busy || guard < 3) && guard < 1200) begin
      tick();
      if (!m_busy) guard++;
      else guard = (guard > 0) ? guard : 0;
      n_checks++;
      if (ser_tx !== m_line) begin n_fail++; $display("FAIL bp_line t=%0d: got %b want %b", m_t, ser_tx, m_line); end
      if (rec_q.size() > 1200) break;
    end
    for (int j = 0; j < 20; j++) begin
      b = decode(2 + 40*j, 4);
      n_checks++;
      if (b !== 8'(base + j)) begin n_fail++; $display("FAIL bp_order byte %0d: got %02h want %02h", j, b, 8'(base + j)); end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_div_change();
    logic [7:0] bytes [3];
    int err;
    cfg_div = 32'd6;
    rec_q.delete();
    for (int i = 0; i < 3; i++) begin
      bytes[i] = 8'($urandom);
      in_valid = 1'b1; in_data = bytes[i];
      tick();
    end
    in_valid = 1'b0;
    while (rec_q.size() < 190) begin
      tick();
      n_checks++;
      if (ser_tx !== m_line) begin n_fail++; $display("FAIL div_line t=%0d: got %b want %b", m_t, ser_tx, m_line); end
      if (rec_q.size() == 30)  cfg_div = 32'd10;
      if (rec_q.size() == 100) cfg_div = 32'd1;
    end
    n_checks += 7;
    if (rec_q[61] !== 1'b1 || rec_q[62] !== 1'b0) begin n_fail++; $display("FAIL div_frame1_len: edge got %b%b want 10", rec_q[61], rec_q[62]); end
    if (rec_q[161] !== 1'b1 || rec_q[162] !== 1'b0) begin n_fail++; $display("FAIL div_frame2_len: edge got %b%b want 10", rec_q[161], rec_q[162]); end
    if (decode(2, 6) !== bytes[0])    begin n_fail++; $display("FAIL div_byte0: got %02h want %02h", decode(2, 6), bytes[0]); end
    if (decode(62, 10) !== bytes[1])  begin n_fail++; $display("FAIL div_byte1: got %02h want %02h", decode(62, 10), bytes[1]); end
    if (decode(162, 2) !== bytes[2])  begin n_fail++; $display("FAIL div_byte2: got %02h want %02h", decode(162, 2), bytes[2]); end
    err = 0;
    for (int i = 181; i < 190; i++) if (rec_q[i] !== 1'b1) err++;
    if (err != 0) begin n_fail++; $display("FAIL div_frame3_len: %0d low cycles after frame 3 want 0", err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL div_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_reset_midframe();
    int first;
    int err;
    cfg_div = 32'd4;
    rec_q.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? (8'($urandom) & 8'hF7) : 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    while (rec_q.size() < 18) tick();
    n_checks++;
    if (fifo_level !== 5'd3) begin n_fail++; $display("FAIL midrst_pre_level: got %0d want 3", fifo_level); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks += 3;
    if (ser_tx !== 1'b1)     begin n_fail++; $display("FAIL midrst_ser_tx: got %b want 1", ser_tx); end
    if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL midrst_level: got %0d want 0", fifo_level); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    repeat (3) begin
      tick();
      n_checks++;
      if (ser_tx !== 1'b1) begin n_fail++; $display("FAIL midrst_idle_line: got %b want 1", ser_tx); end
    end
    rec_q.delete();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    repeat (45) begin
      tick();
      n_checks++;
      if (ser_tx !== m_line) begin n_fail++; $display("FAIL midrst_line t=%0d: got %b want %b", m_t, ser_tx, m_line); end
    end
    first = -1;
    foreach (rec_q[i]) if (rec_q[i] === 1'b0 && first < 0) first = i;
    err = 0;
    for (int i = 42; i < 46; i++) if (rec_q[i] !== 1'b1) err++;
    n_checks += 3;
    if (first != 2) begin n_fail++; $display("FAIL midrst_start: got %0d want 2", first); end
    if (decode(2, 4) !== 8'hA5) begin n_fail++; $display("FAIL midrst_byte: got %02h want a5", decode(2, 4)); end
    if (err != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_single_frame: low after=%0d busy=%b want 0,0", err, busy); end
  endtask

  task automatic test_random();
    int guard;
    rec_q.delete();
    repeat (600) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_data  = 8'($urandom);
      cfg_div  = 32'($urandom_range(0, 7));
      tick();
      n_checks += 4;
      if (ser_tx !== m_line)   begin n_fail++; $display("FAIL rnd_line t=%0d: got %b want %b", m_t, ser_tx, m_line); end
      if (busy !== m_busy)     begin n_fail++; $display("FAIL rnd_busy t=%0d: got %b want %b", m_t, busy, m_busy); end
      if (in_ready !== m_ready) begin n_fail++; $display("FAIL rnd_in_ready t=%0d: got %b want %b", m_t, in_ready, m_ready); end
      if (fifo_level !== 5'(m_level)) begin n_fail++; $display("FAIL rnd_level t=%0d: got %0d want %0d", m_t, fifo_level, m_level); end
    end
    in_valid = 1'b0;
    guard = 0;
    while (m_busy && guard < 2000) begin
      cfg_div = 32'($urandom_range(0, 7));
      tick();
      guard++;
      n_checks += 2;
      if (ser_tx !== m_line) begin n_fail++; $display("FAIL rnd_drain_line t=%0d: got %b want %b", m_t, ser_tx, m_line); end
      if (busy !== m_busy)   begin n_fail++; $display("FAIL rnd_drain_busy t=%0d: got %b want %b", m_t, busy, m_busy); end
    end
    n_checks++;
    if (m_busy || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_drain_timeout: busy got %b want 0", busy); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; cfg_div = 32'd6;
    test_reset();
    test_single();
    test_hello();
    test_backpressure();
    test_div_change();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
